// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and the
// default 10-hour wrap modulus used by the count-to-watch formatter.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  localparam int unsigned WRAP_MS_DEFAULT    = 36000000;
  localparam int unsigned CLK_PER_MS_DEFAULT = 50000;

  function automatic logic is_counting(input state_e s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_ms_prescaler.sv
// Millisecond prescaler: counts clock cycles while enabled and flags the
// terminal count. The count holds while disabled so a paused fraction survives.
module ms_prescaler #(
  parameter int unsigned CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic nreset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = en && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button edge detection, run/lap/pause FSM,
// wrapping millisecond counter and frozen lap value for display.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = CLK_PER_MS_DEFAULT,
  parameter int unsigned BITS       = 26,
  parameter int unsigned WRAP_MS    = WRAP_MS_DEFAULT
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            start_stop,
  input  logic            lap,
  input  logic            clear,
  output logic [BITS-1:0] count,
  output logic [BITS-1:0] disp_count,
  output logic            running,
  output logic            lap_active,
  output logic            ms_tick
);

  localparam logic [BITS-1:0] COUNT_MAX = BITS'(WRAP_MS - 1);

  state_e          state_q, state_d;
  logic [BITS-1:0] count_q, count_d;
  logic [BITS-1:0] lap_q, lap_d;
  logic            ss_prev_q, lap_prev_q, clr_prev_q;
  logic            ms_tick_q, ms_tick_d;
  logic            tick;

  // Only the highest-priority rising edge acts: clear > start_stop > lap.
  logic act_clr, act_ss, act_lap;
  assign act_clr = clear & ~clr_prev_q;
  assign act_ss  = start_stop & ~ss_prev_q & ~act_clr;
  assign act_lap = lap & ~lap_prev_q & ~act_clr & ~(start_stop & ~ss_prev_q);

  ms_prescaler #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_presc (
    .clk   (clk),
    .nreset(nreset),
    .en    (is_counting(state_q)),
    .clr   (act_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    lap_d     = lap_q;
    count_d   = count_q;
    ms_tick_d = tick & ~act_clr;

    if (tick) begin
      count_d = (count_q == COUNT_MAX) ? '0 : count_q + BITS'(1);
    end

    unique case (state_q)
      IDLE:  if (act_ss) state_d = RUN;
      RUN: begin
        if (act_ss) begin
          state_d = PAUSE;
        end else if (act_lap) begin
          state_d = LAP;
          lap_d   = count_q;
        end
      end
      LAP: begin
        if (act_ss)       state_d = PAUSE;
        else if (act_lap) state_d = RUN;
      end
      PAUSE: if (act_ss) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (act_clr) begin
      state_d = IDLE;
      count_d = '0;
      lap_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      lap_q      <= '0;
      ss_prev_q  <= 1'b0;
      lap_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
      ms_tick_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lap_q      <= lap_d;
      ss_prev_q  <= start_stop;
      lap_prev_q <= lap;
      clr_prev_q <= clear;
      ms_tick_q  <= ms_tick_d;
    end
  end

  assign count      = count_q;
  assign disp_count = (state_q == LAP) ? lap_q : count_q;
  assign running    = is_counting(state_q);
  assign lap_active = (state_q == LAP);
  assign ms_tick    = ms_tick_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a small prescale and 12 ms wrap;
// expected output snapshots are queued as stimulus is applied and checked later.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  localparam int unsigned CPM  = 4;
  localparam int unsigned BITS = 26;
  localparam int unsigned WRAP = 12;

  logic            clk;
  logic            nreset;
  logic            start_stop, lap, clear;
  logic [BITS-1:0] count, disp_count;
  logic            running, lap_active, ms_tick;

  typedef struct packed {
    logic [BITS-1:0] cnt;
    logic [BITS-1:0] disp;
    logic            run;
    logic            lapa;
    logic            tk;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   tick_cnt = 0;
  int   tick_snap;

  stopwatch_ctrl #(
    .CLK_PER_MS(CPM),
    .BITS      (BITS),
    .WRAP_MS   (WRAP)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .count     (count),
    .disp_count(disp_count),
    .running   (running),
    .lap_active(lap_active),
    .ms_tick   (ms_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ms_tick === 1'b1) tick_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s.%s observed %0d expected %0d", tag, fld, obs, exp);
    end
  endtask

  task automatic push(input int c, input int d, input logic r, input logic l, input logic t);
    exp_t e;
    e.cnt  = BITS'(c);
    e.disp = BITS'(d);
    e.run  = r;
    e.lapa = l;
    e.tk   = t;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL %s scoreboard empty, observed count %0d expected an entry", tag, count);
      return;
    end
    e = sb.pop_front();
    cmp(tag, "count",      32'(count),      32'(e.cnt));
    cmp(tag, "disp_count", 32'(disp_count), 32'(e.disp));
    cmp(tag, "running",    32'(running),    32'(e.run));
    cmp(tag, "lap_active", 32'(lap_active), 32'(e.lapa));
    cmp(tag, "ms_tick",    32'(ms_tick),    32'(e.tk));
  endtask

  // Queue the expectation, advance n cycles, then compare against the DUT.
  task automatic exp_step(input string tag, input int n, input int c, input int d,
                          input logic r, input logic l, input logic t);
    push(c, d, r, l, t);
    step(n);
    check(tag);
  endtask

  initial begin
    nreset = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
    clear = 1'b0;
    push(0, 0, 0, 0, 0);
    #2;
    check("reset");
    step(1);
    nreset = 1'b1;
    exp_step("idle", 2, 0, 0, 0, 0, 0);

    // Start and count 10 ms.
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    tick_snap = tick_cnt;
    exp_step("run40", 40, 10, 10, 1, 0, 1);
    exp_step("run41", 1, 10, 10, 1, 0, 0);
    cmp("run41", "tick_pulses", 32'(tick_cnt - tick_snap), 32'd10);

    // Pause with presc=2, hold 20 cycles, resume: tick two cycles later.
    start_stop = 1'b1;
    exp_step("pause", 1, 10, 10, 0, 0, 0);
    start_stop = 1'b0;
    exp_step("pause_hold", 20, 10, 10, 0, 0, 0);
    cmp("pause_hold", "tick_pulses", 32'(tick_cnt - tick_snap), 32'd10);
    start_stop = 1'b1;
    exp_step("resume", 1, 10, 10, 1, 0, 0);
    start_stop = 1'b0;
    exp_step("resume_p1", 1, 10, 10, 1, 0, 0);
    exp_step("resume_p2", 1, 11, 11, 1, 0, 1);

    // Wrap 11 -> 0 staying in RUN.
    exp_step("wrap", 4, 0, 0, 1, 0, 1);

    // Clear from RUN.
    clear = 1'b1;
    exp_step("clear_run", 1, 0, 0, 0, 0, 0);
    clear = 1'b0;

    // Lap at count 5, then 12 more cycles.
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    exp_step("to5", 20, 5, 5, 1, 0, 1);
    lap = 1'b1;
    exp_step("lap_in", 1, 5, 5, 1, 1, 0);
    lap = 1'b0;
    exp_step("lap_frozen", 11, 8, 5, 1, 1, 1);
    lap = 1'b1;
    exp_step("lap_out", 1, 8, 8, 1, 0, 0);
    lap = 1'b0;

    // Lap edge coinciding with a tick captures the pre-increment count.
    step(2);
    lap = 1'b1;
    exp_step("lap_on_tick", 1, 9, 8, 1, 1, 1);
    lap = 1'b0;
    step(1);
    lap = 1'b1;
    exp_step("lap_back", 1, 9, 9, 1, 0, 0);
    lap = 1'b0;
    step(1);

    // All three edges together on a tick cycle: clear wins, no increment.
    clear = 1'b1;
    start_stop = 1'b1;
    lap = 1'b1;
    exp_step("all_three", 1, 0, 0, 0, 0, 0);
    clear = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
    step(1);

    // start_stop + lap together in RUN: pause, no lap capture.
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    exp_step("to1", 4, 1, 1, 1, 0, 1);
    start_stop = 1'b1;
    lap = 1'b1;
    exp_step("ss_lap", 1, 1, 1, 0, 0, 0);
    start_stop = 1'b0;
    lap = 1'b0;
    step(1);
    lap = 1'b1;
    exp_step("lap_in_pause", 1, 1, 1, 0, 0, 0);
    lap = 1'b0;
    step(1);

    // Stop edge on a tick cycle still applies the increment.
    start_stop = 1'b1;
    exp_step("resume2", 1, 1, 1, 1, 0, 0);
    start_stop = 1'b0;
    step(2);
    start_stop = 1'b1;
    exp_step("stop_on_tick", 1, 2, 2, 0, 0, 1);
    start_stop = 1'b0;
    step(1);

    // Enter LAP, then assert reset between clock edges.
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    lap = 1'b1;
    exp_step("lap_again", 1, 2, 2, 1, 1, 0);
    lap = 1'b0;
    step(5);
    #3;
    start_stop = 1'b1;
    nreset = 1'b0;
    push(0, 0, 0, 0, 0);
    #1;
    check("async_rst");
    exp_step("rst_hold", 2, 0, 0, 0, 0, 0);
    #2;
    nreset = 1'b1;
    exp_step("rel_held", 1, 0, 0, 1, 0, 0);
    exp_step("held_no_retrig", 4, 1, 1, 1, 0, 1);
    start_stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
